imm_decode_stage: RTL and testbench

//  Decode-side sequencer for the RV64 immediate generator. Accepts fetched instructions over a

---
 rtl/imm_pkg.sv | 35 +++
 rtl/imm_decode_stage_type_dec.sv | 44 ++++
 rtl/imm_decode_stage.sv | 106 ++++++++++
 tb/tb_imm_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate decode stage.
// Select codes, RV64 major opcodes and occupancy states.
package imm_pkg;

  localparam int IMM_XLEN  = 64;
  localparam int IMM_DEPTH = 2;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_SB   = 3'd2;
  localparam logic [2:0] IMM_NONE = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_UJ   = 3'd5;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_decode_stage_type_dec.sv
// Opcode classifier: opcode -> immediate select and illegal flag.
// Illegal flagging only when IMM_ILLEGAL_CHK_EN is defined.
module imm_type_dec
  import imm_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       illegal
);

  logic is_i;
  logic is_s;
  logic is_sb;
  logic is_u;
  logic is_uj;
  logic is_r;

  always_comb begin
    is_i  = opcode inside {OP_LOAD, OP_IMM, OP_IMM32,
                           OP_JALR, OP_SYSTEM, OP_MISC_MEM};
    is_s  = (opcode == OP_STORE);
    is_sb = (opcode == OP_BRANCH);
    is_u  = opcode inside {OP_LUI, OP_AUIPC};
    is_uj = (opcode == OP_JAL);
    is_r  = opcode inside {OP_OP, OP_OP32};
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i:  imm_sel = IMM_I;
      is_s:  imm_sel = IMM_S;
      is_sb: imm_sel = IMM_SB;
      is_u:  imm_sel = IMM_U;
      is_uj: imm_sel = IMM_UJ;
      is_r:  imm_sel = IMM_NONE;
      default: begin
        imm_sel = IMM_NONE;
`ifdef IMM_ILLEGAL_CHK_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage with a 2-entry skid queue toward execute.
// Optional illegal-opcode flag: define IMM_ILLEGAL_CHK_EN.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = IMM_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic [2:0]      imm_sel,
  input  logic [XLEN-1:0] imm_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } entry_t;

  localparam entry_t RST_E = '{
    inst: '0, imm: '0, typ: IMM_NONE, ill: 1'b0
  };

  occ_e   state_q;
  occ_e   state_d;
  entry_t head_q;
  entry_t tail_q;
  entry_t new_e;
  logic   [2:0] sel;
  logic   ill;
  logic   push;
  logic   pop;

  imm_type_dec u_dec (
    .opcode  (in_inst[6:0]),
    .imm_sel (sel),
    .illegal (ill)
  );

  assign imm_sel   = sel;
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // R-type carries no immediate, so the generator value is ignored
  always_comb begin
    new_e.inst = in_inst;
    new_e.imm  = (sel == IMM_NONE) ? '0 : imm_val;
    new_e.typ  = sel;
    new_e.ill  = ill;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL: if (pop) state_d = ST_ONE;
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= RST_E;
      tail_q <= RST_E;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (push) head_q <= new_e;
        ST_ONE: begin
          if (push && pop) head_q <= new_e;
          else if (push)   tail_q <= new_e;
        end
        ST_FULL: if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  assign out_inst    = head_q.inst;
  assign out_imm     = head_q.imm;
  assign out_type    = head_q.typ;
  assign out_illegal = head_q.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage.
// Queue-based reference model with an RV64 immediate generator.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        flush;
  logic [2:0]  imm_sel;
  logic [63:0] imm_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_imm;
  logic [2:0]  out_type;
  logic        out_illegal;
  logic [63:0] junk;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t q[$];

  imm_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .flush       (flush),
    .imm_sel     (imm_sel),
    .imm_val     (imm_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_imm     (out_imm),
    .out_type    (out_type),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_type(input logic [31:0] inst);
    case (inst[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F: return 3'd0;
      7'h23: return 3'd1;
      7'h63: return 3'd2;
      7'h37, 7'h17: return 3'd4;
      7'h6F: return 3'd5;
      default: return 3'd3;
    endcase
  endfunction

  function automatic logic ref_known(input logic [31:0] inst);
    return (ref_type(inst) != 3'd3) ||
           (inst[6:0] == 7'h33) || (inst[6:0] == 7'h3B);
  endfunction

  function automatic logic ref_ill(input logic [31:0] inst);
`ifdef IMM_ILLEGAL_CHK_EN
    return !ref_known(inst);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] gen_imm(input logic [31:0] inst);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    logic signed [63:0] r;
    r = 0;
    case (ref_type(inst))
      3'd0: begin i12 = inst[31:20]; r = i12; end
      3'd1: begin i12 = {inst[31:25], inst[11:7]}; r = i12; end
      3'd2: begin
        b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        r = b13;
      end
      3'd4: begin u32 = {inst[31:12], 12'h000}; r = u32; end
      3'd5: begin
        j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        r = j21;
      end
      default: r = 0;
    endcase
    return r;
  endfunction

  always_comb begin
    imm_val = (ref_type(in_inst) == 3'd3) ? junk : gen_imm(in_inst);
  end

  task automatic step(input logic v, input logic [31:0] inst,
                      input logic fl, input logic ordy);
    logic push;
    logic pop;
    exp_t e;
    in_valid  = v;
    in_inst   = inst;
    flush     = fl;
    out_ready = ordy;
    junk      = {$urandom, $urandom} | 64'h1;
    #1;
    checks++;
    if (imm_sel !== ref_type(inst)) begin
      failures++;
      $display("FAIL imm_sel inst=%h got=%0d exp=%0d",
               inst, imm_sel, ref_type(inst));
    end
    push = v && (q.size() < 2) && !fl;
    pop  = (q.size() > 0) && ordy;
    e.inst = inst;
    e.typ  = ref_type(inst);
    e.imm  = (e.typ == 3'd3) ? 64'd0 : gen_imm(inst);
    e.ill  = ref_ill(inst);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (fl) q.delete();
    else if (push) q.push_back(e);
    #1;
    checks++;
    if (in_ready !== (q.size() < 2)) begin
      failures++;
      $display("FAIL in_ready got=%b exp=%b", in_ready, q.size() < 2);
    end
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      failures++;
      $display("FAIL out_valid got=%b exp=%b", out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if (out_inst !== q[0].inst || out_imm !== q[0].imm ||
          out_type !== q[0].typ || out_illegal !== q[0].ill) begin
        failures++;
        $display("FAIL head got=%h/%h/%0d/%b exp=%h/%h/%0d/%b",
                 out_inst, out_imm, out_type, out_illegal,
                 q[0].inst, q[0].imm, q[0].typ, q[0].ill);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_imm !== 64'd0 ||
        out_type !== 3'd3 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s got v=%b i=%h m=%h t=%0d il=%b r=%b exp 0/0/0/3/0/1",
               tag, out_valid, out_inst, out_imm, out_type,
               out_illegal, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_inst = 32'd0; flush = 1'b0;
    out_ready = 1'b0; junk = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_latency();
    step(1'b1, 32'h00500093, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_type !== 3'd0 || out_imm !== 64'd5) begin
      failures++;
      $display("FAIL addi got v=%b t=%0d imm=%h exp 1/0/5",
               out_valid, out_type, out_imm);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_full();
    step(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
    step(1'b1, 32'h0000106F, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_type !== 3'd2 ||
        out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL full got r=%b t=%0d imm=%h exp 0/2/fffffffffffffffc",
               in_ready, out_type, out_imm);
    end
    step(1'b1, 32'h00500093, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1 || out_type !== 3'd5 || out_imm !== 64'h1000) begin
      failures++;
      $display("FAIL full_pop got r=%b t=%0d imm=%h exp 1/5/1000",
               in_ready, out_type, out_imm);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, 32'h00500093, 1'b0, 1'b0);
    step(1'b1, 32'h00A00113, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush got v=%b r=%b exp 0/1", out_valid, in_ready);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_none_illegal();
    step(1'b1, 32'h00B50533, 1'b0, 1'b1);
    checks++;
    if (out_type !== 3'd3 || out_imm !== 64'd0 || out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL add got t=%0d imm=%h il=%b exp 3/0/0",
               out_type, out_imm, out_illegal);
    end
    step(1'b1, 32'h0000007F, 1'b0, 1'b1);
    checks++;
`ifdef IMM_ILLEGAL_CHK_EN
    if (out_illegal !== 1'b1 || out_type !== 3'd3 || out_imm !== 64'd0) begin
      failures++;
      $display("FAIL illegal got il=%b t=%0d imm=%h exp 1/3/0",
               out_illegal, out_type, out_imm);
    end
`else
    if (out_illegal !== 1'b0 || out_type !== 3'd3 || out_imm !== 64'd0) begin
      failures++;
      $display("FAIL illegal got il=%b t=%0d imm=%h exp 0/3/0",
               out_illegal, out_type, out_imm);
    end
`endif
    step(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [6:0] ops [16];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B, 7'h57};
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      step($urandom_range(0, 3) != 0,
           {r[31:7], ops[$urandom_range(0, 15)]},
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h00500093, 1'b0, 1'b0);
    step(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL prefill got r=%b v=%b exp 0/1", in_ready, out_valid);
    end
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h0000106F, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_latency();
    test_full();
    test_flush();
    test_none_illegal();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
